and_term_pipe: RTL and testbench
================================

# and_term_pipe

Parametrised, pipelined successor to the fixed AND/NOT output network: each output bit is a runtime-programmable product term (AND of selected, optionally inverted, input bits, with optional output inversion). Terms are loaded through a configuration write port; input vectors flow through a STAGES-deep valid/ready pipeline. It sits between the vector stimulus source and the result capture logic in the simulation benches.

## Interface
- IN_W, 20, input vector width (≥1)
- OUT_W, 10, number of output bits / product terms (≥1)
- STAGES, 2, pipeline depth in cycles (≥1)
- CNT_W, 16, width of the accepted-result counter
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset; synchronous and active-high
- cfg_we  input  1  write one term's configuration this cycle
- cfg_addr  input  clog2(OUT_W) (min 1)  term index
- cfg_mask  input  IN_W  bit i set = in[i] participates in the term
- cfg_pol  input  IN_W  bit i set = in[i] inverted before the AND
- cfg_oinv  input  1  invert the term result
- in_valid  input  1  input vector present
- in_ready  output  1  pipeline accepts a vector this cycle
- in_data  input  IN_W  input vector
- out_valid  output  1  result present at pipeline tail
- out_ready  input  1  consumer takes the result
- out_data  output  OUT_W  result vector
- res_cnt  output  CNT_W  number of completed output handshakes, saturating

## Operation
- Term j: t = AND over i where mask_j[i]=1 of (in_data[i] XOR pol_j[i]); out_data[j] = t XOR oinv_j. Empty mask -> t = 1.
- Evaluation happens combinationally in the accept cycle and is written into stage 0; later stages only delay. In-flight results therefore reflect the config at their accept cycle.
- Config write: when cfg_we=1, term cfg_addr's mask/pol/oinv update at the clock edge. cfg_addr ≥ OUT_W -> write ignored.
- in_ready = !cfg_we && (pipeline not stalled). Stall rule: the whole pipeline advances only when tail is empty or out_ready=1; in_ready = !cfg_we && (!out_valid || out_ready). No bubble collapsing required.
- Accept = in_valid && in_ready. When pipeline advances without accept, a bubble (valid=0) enters stage 0.
- res_cnt increments on out_valid && out_ready; holds at 2^CNT_W−1.
- Reset: all masks, pols, oinv = 0 (every term reads 1); all stage valids = 0; out_valid = 0; out_data = 0; res_cnt = 0; in_ready = 1 in the cycle after reset deasserts (if cfg_we=0).
- Reset asserted mid-operation discards all in-flight vectors and config; no output handshake completes in a reset cycle.

## Timing
- Latency: vector accepted at edge N appears with out_valid=1 after edge N+STAGES−1 (visible in the cycle following that edge) when no stall; STAGES=1 gives a one-register delay.
- Throughput: one vector per cycle when out_ready held high and cfg_we=0.
- out_data/out_valid stable while out_valid=1 && out_ready=0.
- Simultaneous cfg_we and in_valid: no accept that cycle; config updates; vector accepted no earlier than next cycle.
- Config written at edge N affects vectors accepted at edge N+1 onward.
- Counter saturation and tail handshake in same cycle: count stays saturated, handshake still completes.

## Test plan
- Post-reset, no config, IN_W=20/OUT_W=10/STAGES=2: send in_data=0x00000 -> out_data=0x3FF after 2 cycles, res_cnt=1.
- Program term 1 mask=bits{2,4,6,10,11}, pol=0; send in_data with those bits set (0x00C54) -> out_data[1]=1; clear bit 10 (0x00854) -> out_data[1]=0.
- Program terms 2..5 mask=bit{5..8} respectively, pol same bit, oinv=0; send 0x00000 -> out_data[5:2]=4'b1111; send 0x001E0 -> 4'b0000.
- Backpressure: stream 8 vectors with out_ready toggling 1,0,0,1,…; all 8 results appear in order, unchanged while stalled, res_cnt=8.
- cfg_we asserted together with in_valid: in_ready=0 that cycle; vector accepted next cycle and evaluated with the new config; a vector already in flight keeps the old-config result.
- Assert rst with 2 vectors in flight -> out_valid=0, res_cnt=0, all terms back to 1 (out_data=0x3FF for next vector).

Source files
------------

// File: rtl/and_term_pipe.sv
// Runtime-programmable product-term network: each output bit is an AND of selected, optionally
// inverted input bits, evaluated on accept and then delayed through a STAGES-deep valid/ready pipe.
module and_term_pipe #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 10,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16,
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [IN_W-1:0]  cfg_mask,
  input  logic [IN_W-1:0]  cfg_pol,
  input  logic             cfg_oinv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] res_cnt
);

  logic [IN_W-1:0]  mask_q [OUT_W];
  logic [IN_W-1:0]  pol_q  [OUT_W];
  logic [OUT_W-1:0] oinv_q;

  logic [STAGES-1:0] vld_q;
  logic [OUT_W-1:0]  dat_q [STAGES];

  logic             advance;
  logic             accept;
  logic [OUT_W-1:0] eval;

  // The whole pipe moves in lockstep; a config write blocks accepts but not the drain.
  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = !cfg_we && advance;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];

  // Non-participating bits are forced to 1 so an empty mask yields a true term.
  always_comb begin
    eval = '0;
    for (int j = 0; j < OUT_W; j++) begin
      eval[j] = (&((in_data ^ pol_q[j]) | ~mask_q[j])) ^ oinv_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < OUT_W; j++) begin
        mask_q[j] <= '0;
        pol_q[j]  <= '0;
      end
      oinv_q <= '0;
    end else if (cfg_we && (int'(cfg_addr) < OUT_W)) begin
      mask_q[cfg_addr] <= cfg_mask;
      pol_q[cfg_addr]  <= cfg_pol;
      oinv_q[cfg_addr] <= cfg_oinv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= eval;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (out_valid && out_ready && (res_cnt != {CNT_W{1'b1}})) begin
      res_cnt <= res_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_and_term_pipe.sv
// Bench for and_term_pipe: directed scenarios plus random traffic against a term-counting model.
module tb_and_term_pipe;
  localparam int IN_W   = 20;
  localparam int OUT_W  = 10;
  localparam int STAGES = 2;
  localparam int CNT_W  = 16;
  localparam int AW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [IN_W-1:0]  cfg_mask;
  logic [IN_W-1:0]  cfg_pol;
  logic             cfg_oinv;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] res_cnt;

  and_term_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_pol(cfg_pol), .cfg_oinv(cfg_oinv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: term config as plain arrays, expected results in arrival order.
  logic [IN_W-1:0]  m_mask [OUT_W];
  logic [IN_W-1:0]  m_pol  [OUT_W];
  logic             m_oinv [OUT_W];
  logic [OUT_W-1:0] exp_q [$];
  int               m_cnt;
  logic [OUT_W-1:0] last_out;
  logic             prev_stall;
  logic [OUT_W-1:0] prev_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [OUT_W-1:0] ref_eval(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int j = 0; j < OUT_W; j++) begin
      int need;
      int hits;
      need = 0;
      hits = 0;
      for (int i = 0; i < IN_W; i++) begin
        if (m_mask[j][i]) begin
          need++;
          if (d[i] != m_pol[j][i]) hits++;
        end
      end
      r[j] = (hits == need) ^ m_oinv[j];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < OUT_W; j++) begin
      m_mask[j] = '0;
      m_pol[j]  = '0;
      m_oinv[j] = 1'b0;
    end
    exp_q.delete();
    m_cnt      = 0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check combinational/handshake outputs, advance the model.
  task automatic cyc(input logic we, input int addr, input logic [IN_W-1:0] mk,
                     input logic [IN_W-1:0] pl, input logic oi, input logic iv,
                     input logic [IN_W-1:0] d, input logic ordy, output logic acc);
    @(negedge clk);
    cfg_we = we; cfg_addr = AW'(addr); cfg_mask = mk; cfg_pol = pl; cfg_oinv = oi;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_dat);
    end
    if (we) chk("rdy_cfg", in_ready, 0);
    else if (exp_q.size() == 0 || ordy) chk("rdy_free", in_ready, 1);
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        last_out = out_data;
        chk("out_data", out_data, exp_q.pop_front());
      end
      m_cnt++;
    end
    prev_stall = out_valid && !ordy;
    prev_dat   = out_data;
    acc = iv && in_ready;
    if (acc) exp_q.push_back(ref_eval(d));
    if (we && addr < OUT_W) begin
      m_mask[addr] = mk;
      m_pol[addr]  = pl;
      m_oinv[addr] = oi;
    end
    @(posedge clk);
    #1;
    chk("res_cnt", res_cnt, m_cnt);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cyc(0, 0, '0, '0, 0, 0, '0, ordy, a);
  endtask

  task automatic send(input logic [IN_W-1:0] d, output logic acc);
    cyc(0, 0, '0, '0, 0, 1, d, 1, acc);
  endtask

  task automatic cfg(input int addr, input logic [IN_W-1:0] mk, input logic [IN_W-1:0] pl,
                     input logic oi);
    logic a;
    cyc(1, addr, mk, pl, oi, 0, '0, 1, a);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cfg_we = 0; in_valid = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", res_cnt, 0);
    model_clear();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int sent;
    int base;
    rst = 1; cfg_we = 0; cfg_addr = '0; cfg_mask = '0; cfg_pol = '0; cfg_oinv = 0;
    in_valid = 0; in_data = '0; out_ready = 0; last_out = '0;
    model_clear();
    do_reset();

    // Empty config: every term reads 1; two-cycle latency.
    cyc(0, 0, '0, '0, 0, 1, 20'h00000, 0, a);
    chk("t0_acc", a, 1);
    chk("lat_early", out_valid, 0);
    idle(0);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 10'h3FF);
    idle(1);
    chk("t0_cnt", res_cnt, 1);

    // Term 1 over bits {2,4,6,10,11}.
    cfg(1, 20'h00C54, '0, 0);
    send(20'h00C54, a);
    drain();
    chk("t1_hit", last_out[1], 1);
    send(20'h00854, a);
    drain();
    chk("t1_miss", last_out[1], 0);

    // Terms 2..5: single inverted bit 5..8.
    for (int j = 2; j <= 5; j++) cfg(j, 20'(1) << (j + 3), 20'(1) << (j + 3), 0);
    send(20'h00000, a);
    drain();
    chk("t25_zero", last_out[5:2], 4'b1111);
    send(20'h001E0, a);
    drain();
    chk("t25_ones", last_out[5:2], 4'b0000);

    // Out-of-range address is ignored.
    cfg(12, '1, '0, 1);
    send(20'h00000, a);
    drain();

    // Backpressure stream of 8 random vectors.
    base = m_cnt;
    sent = 0;
    for (int k = 0; k < 200 && sent < 8; k++) begin
      cyc(0, 0, '0, '0, 0, 1, IN_W'($urandom), (k % 3) == 0, a);
      if (a) sent++;
    end
    chk("bp_sent", sent, 8);
    drain();
    chk("bp_cnt", res_cnt, base + 8);

    // Config write collides with a vector; in-flight vector keeps the old term 0.
    send(20'h00003, a);
    cyc(1, 0, 20'h00001, '0, 0, 1, 20'h00002, 1, a);
    chk("cfg_block", a, 0);
    send(20'h00002, a);
    chk("cfg_next_acc", a, 1);
    drain();
    chk("cfg_new_term", last_out[0], 0);

    // Random traffic with random configuration writes.
    for (int k = 0; k < 300; k++) begin
      logic [IN_W-1:0] mk;
      mk = IN_W'($urandom) & IN_W'($urandom);
      cyc(($urandom % 6) == 0, $urandom % 16, mk, IN_W'($urandom), 1'($urandom),
          1'($urandom), IN_W'($urandom), ($urandom % 4) != 0, a);
    end
    drain();

    // Reset with two vectors in flight.
    send(20'h12345, a);
    cyc(0, 0, '0, '0, 0, 1, 20'h0ABCD, 0, a);
    do_reset();
    chk("rst_rdy", in_ready, 1);
    send(20'h00000, a);
    drain();
    chk("rst_terms", last_out, 10'h3FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
